issue_ctrl: RTL
===============

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock, rising edge; i_rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: i_fetch_valid  in  1  instruction offered; o_fetch_ready  out  1  instruction accepted when both high.
REQ-003 SHALL have ports: i_bundle  in  57  decoder bundle {rs1[56:52], rs2[51:47], rd[46:42], unit[41:39], op[38:36], func[35:33], imm[32:1], flag[0]}; i_dec_valid  in  1  decoder legality; i_cflow  in  1  instruction is branch/jal/jalr.
REQ-004 SHALL have ports: o_issue_valid  out  1; o_issue_bundle  out  57; o_issue_unit  out  3; i_unit_ready  in  5  one bit per unit (0 ASB, 1 LOGIC, 2 LOAD, 3 STORE, 4 ENV).
REQ-005 SHALL have ports: i_wb_valid  in  1; i_wb_rd  in  5  register written back; i_redirect  in  1  control-flow resolved; o_trap  out  1  illegal instruction; i_trap_ack  in  1.

Function
REQ-006 SHALL be an FSM with states EMPTY, HOLD, CFLOW_WAIT, TRAP, plus a single-entry bundle register.
REQ-007 SHALL accept (fire) when i_fetch_valid && o_fetch_ready; o_fetch_ready = (EMPTY) || (HOLD && issue fires this cycle && held entry not cflow).
REQ-008 On accept with i_dec_valid=1 and unit<=4: latch bundle and i_cflow, go HOLD; earliest o_issue_valid is the cycle after accept (latency 1).
REQ-009 On accept with i_dec_valid=0 or unit>4: go TRAP, o_trap=1, nothing issued; TRAP exits to EMPTY on i_trap_ack only.
REQ-010 Scoreboard: 32 busy bits, bit 0 never set.
REQ-011 Hazard = busy[rs1] || busy[rs2] || busy[rd]; rs2 checked even for immediate forms (conservative).
REQ-012 ENV unit entries SHALL additionally wait until the entire scoreboard is clear (serialising).
REQ-013 In HOLD: o_issue_valid = !hazard; issue fires when o_issue_valid && i_unit_ready[o_issue_unit]; once asserted, o_issue_valid and o_issue_bundle hold stable until fire.
REQ-014 On fire: set busy[rd] if rd!=0 and unit is ASB/LOGIC/LOAD and not (unit==ASB && op==0 branch); STORE, ENV, branches never set busy.
REQ-015 On i_wb_valid: clear busy[i_wb_rd]; simultaneous set and clear of the same register -> set wins.
REQ-016 After fire: cflow entry -> CFLOW_WAIT; else next accepted entry -> HOLD (back-to-back), or EMPTY if none.
REQ-017 CFLOW_WAIT: o_fetch_ready=0, o_issue_valid=0; i_redirect -> EMPTY; i_redirect ignored in all other states.
REQ-018 o_issue_bundle and o_issue_unit SHALL be zero whenever o_issue_valid=0.

Reset
REQ-019 i_rst high at a clock edge SHALL, regardless of state, force EMPTY, clear scoreboard and bundle register, drive o_issue_valid=0, o_trap=0, and hold o_fetch_ready=0 while asserted.
REQ-020 o_fetch_ready SHALL be 1 in the first cycle after i_rst deasserts; a mid-operation reset discards held, in-flight and trap state without issuing.

Configuration
REQ-021 Macro ISSUE_WB_BYPASS_EN: when defined, a register written back this cycle (i_wb_valid, i_wb_rd) SHALL be treated as not busy in the hazard check of the same cycle.
REQ-022 Without ISSUE_WB_BYPASS_EN, hazard uses registered scoreboard only, costing one extra stall cycle per writeback-dependent instruction.

Verification
REQ-023 addi x5 accepted cycle 0, i_unit_ready=5'b11111 -> o_issue_valid cycle 1, unit 0, busy[5]=1 cycle 2.
REQ-024 add x6,x5,x5 after REQ-023 with no writeback -> stalls; i_wb_valid, i_wb_rd=5 at cycle 5 -> issue cycle 5 with ISSUE_WB_BYPASS_EN, cycle 6 without.
REQ-025 beq, i_cflow=1 -> issued, o_fetch_ready=0 until i_redirect pulse; EMPTY and o_fetch_ready=1 the cycle after.
REQ-026 Accept with i_dec_valid=0 -> o_trap=1 next cycle, no issue, o_fetch_ready=0; i_trap_ack -> EMPTY.
REQ-027 sw issued with i_unit_ready[3]=0 for 3 cycles -> o_issue_valid and bundle stable, fires cycle 4, no busy bit set.
REQ-028 i_rst pulsed in HOLD with busy[7]=1 -> scoreboard 0, o_issue_valid=0, o_fetch_ready=1 after release.

Source files
------------

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl -- single-entry in-order issue stage with register scoreboard.
//
// An instruction from the decoder is accepted into a one-entry holding
// register. It is issued to one of five execution units once its source and
// destination registers are free in the scoreboard. Control-flow
// instructions block further fetch until the redirect arrives. Illegal
// instructions raise a trap, which stays up until it is acknowledged.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), synchronous active-high reset
//   i_fetch_valid        instruction offered by fetch/decode
//   o_fetch_ready        instruction accepted when valid && ready
//   i_bundle[56:0]       {rs1,rs2,rd,unit,op,func,imm,flag}
//   i_dec_valid          decoder says the instruction is legal
//   i_cflow              instruction is branch/jal/jalr
//   o_issue_valid        held instruction is hazard-free and offered
//   o_issue_bundle/unit  issued bundle and target unit (zero when not valid)
//   i_unit_ready[4:0]    per-unit ready (0 ASB,1 LOGIC,2 LOAD,3 STORE,4 ENV)
//   i_wb_valid, i_wb_rd  writeback clears the scoreboard bit of i_wb_rd
//   i_redirect           control flow resolved (only used in CFLOW_WAIT)
//   o_trap, i_trap_ack   illegal-instruction trap and its acknowledge
//
// Build option: define ISSUE_WB_BYPASS_EN to let a same-cycle writeback
// clear the hazard immediately instead of one cycle later.
// -----------------------------------------------------------------------------
module issue_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic [56:0] i_bundle,
  input  logic        i_dec_valid,
  input  logic        i_cflow,
  output logic        o_issue_valid,
  output logic [56:0] o_issue_bundle,
  output logic [2:0]  o_issue_unit,
  input  logic [4:0]  i_unit_ready,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_redirect,
  output logic        o_trap,
  input  logic        i_trap_ack
);

  localparam logic [1:0] ST_EMPTY      = 2'd0;
  localparam logic [1:0] ST_HOLD       = 2'd1;
  localparam logic [1:0] ST_CFLOW_WAIT = 2'd2;
  localparam logic [1:0] ST_TRAP       = 2'd3;

  localparam logic [2:0] UNIT_ASB   = 3'd0;
  localparam logic [2:0] UNIT_LOGIC = 3'd1;
  localparam logic [2:0] UNIT_LOAD  = 3'd2;
  localparam logic [2:0] UNIT_ENV   = 3'd4;

  logic [1:0]  state_reg, state_next;
  logic [56:0] bundle_reg, bundle_next;
  logic        cflow_reg, cflow_next;
  logic [31:0] busy_reg, busy_next;

  // Fields of the held entry and of the incoming bundle
  logic [4:0] hold_rs1, hold_rs2, hold_rd;
  logic [2:0] hold_unit, hold_op, in_unit;
  assign hold_rs1  = bundle_reg[56:52];
  assign hold_rs2  = bundle_reg[51:47];
  assign hold_rd   = bundle_reg[46:42];
  assign hold_unit = bundle_reg[41:39];
  assign hold_op   = bundle_reg[38:36];
  assign in_unit   = i_bundle[41:39];

  logic [31:0] wb_mask, set_mask, busy_view;
  logic        hazard, issue_valid, fire, fetch_ready, accept, in_legal;
  logic        writes_rd;
  logic [7:0]  unit_ready_ext;

  always_comb begin
    wb_mask = '0;
    if (i_wb_valid) wb_mask[i_wb_rd] = 1'b1;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign busy_view = busy_reg & ~wb_mask;
`else
  assign busy_view = busy_reg;
`endif

  // ENV entries serialise: they wait for every outstanding write to retire.
  assign hazard = busy_view[hold_rs1] | busy_view[hold_rs2] | busy_view[hold_rd]
                | ((hold_unit == UNIT_ENV) && (|busy_view));

  // Held entries always have unit <= 4; the zero extension keeps the index
  // in range for any encoding.
  assign unit_ready_ext = {3'b000, i_unit_ready};

  // Busy bits only get set by this entry's own fire, so once the hazard
  // clears it stays clear and o_issue_valid is stable until fire.
  assign issue_valid = !i_rst && (state_reg == ST_HOLD) && !hazard;
  assign fire        = issue_valid && unit_ready_ext[hold_unit];
  assign fetch_ready = !i_rst && ((state_reg == ST_EMPTY) ||
                                  ((state_reg == ST_HOLD) && fire && !cflow_reg));
  assign accept      = i_fetch_valid && fetch_ready;
  assign in_legal    = i_dec_valid && (in_unit <= UNIT_ENV);

  // Branches are ASB op 0 and have no destination.
  assign writes_rd = (hold_rd != 5'd0) &&
                     (((hold_unit == UNIT_ASB) && (hold_op != 3'd0)) ||
                      (hold_unit == UNIT_LOGIC) || (hold_unit == UNIT_LOAD));

  always_comb begin
    set_mask = '0;
    if (fire && writes_rd) set_mask[hold_rd] = 1'b1;
  end

  // Per-bit scoreboard update: set beats a same-cycle clear; x0 never busy.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = set_mask[gi] | (busy_reg[gi] & ~wb_mask[gi]);
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    bundle_next = bundle_reg;
    cflow_next  = cflow_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) state_next = in_legal ? ST_HOLD : ST_TRAP;
      end
      ST_HOLD: begin
        if (fire) begin
          bundle_next = '0;
          cflow_next  = 1'b0;
          if (cflow_reg)   state_next = ST_CFLOW_WAIT;
          else if (accept) state_next = in_legal ? ST_HOLD : ST_TRAP;
          else             state_next = ST_EMPTY;
        end
      end
      ST_CFLOW_WAIT: begin
        if (i_redirect) state_next = ST_EMPTY;
      end
      default: begin
        if (i_trap_ack) state_next = ST_EMPTY;
      end
    endcase
    if (accept && in_legal) begin
      bundle_next = i_bundle;
      cflow_next  = i_cflow;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_EMPTY;
      bundle_reg <= '0;
      cflow_reg  <= 1'b0;
      busy_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      bundle_reg <= bundle_next;
      cflow_reg  <= cflow_next;
      busy_reg   <= busy_next;
    end
  end

  assign o_fetch_ready  = fetch_ready;
  assign o_issue_valid  = issue_valid;
  assign o_issue_bundle = issue_valid ? bundle_reg : '0;
  assign o_issue_unit   = issue_valid ? hold_unit : 3'd0;
  assign o_trap         = !i_rst && (state_reg == ST_TRAP);

endmodule
